// File: rtl/vga_timing_driver.sv
// vga_timing_driver
// Raster timing generator and pixel output stage for a VGA path (640x480@60 by default).
// Free-running h/v counters produce 1-based pixel coordinates for the compositing
// stage. The returned pixel is registered onto the pins with sync and blanking
// delayed to match the compositor latency.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   VGA_data     RGB444 pixel from compositor, [11:8]=R [7:4]=G [3:0]=B
//   VGA_xpos     1-based column, 0 outside active columns (combinational decode)
//   VGA_ypos     1-based row, 0 outside active lines (combinational decode)
//   frame_start  high while position (1,1) is presented (combinational decode)
//   VGA_r/g/b    registered colour pins, forced to 0 while blanked
//   VGA_hs/vs    registered sync pins, polarity from HS_POL/VS_POL
module vga_timing_driver #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter int unsigned DATA_LATENCY = 3,
    parameter logic        HS_POL       = 1'b0,
    parameter logic        VS_POL       = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] VGA_data,
    output logic [10:0] VGA_xpos,
    output logic [10:0] VGA_ypos,
    output logic        frame_start,
    output logic [3:0]  VGA_r,
    output logic [3:0]  VGA_g,
    output logic [3:0]  VGA_b,
    output logic        VGA_hs,
    output logic        VGA_vs
);

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_active;
    logic             v_active;
    logic             de;
    logic             hs_raw;
    logic             vs_raw;
    logic             de_dly;
    logic             hs_dly;
    logic             vs_dly;

    // Raster counters; reset to the last position so the first edge lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= H_LAST;
            v_cnt <= V_LAST;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_ONE;
        end else begin
            h_cnt <= h_cnt + CNT_ONE;
        end
    end

    // Position-domain decode straight from the counter registers.
    always_comb begin
        h_active    = (h_cnt < H_ACT);
        v_active    = (v_cnt < V_ACT);
        VGA_xpos    = h_active ? h_cnt + CNT_ONE : '0;
        VGA_ypos    = v_active ? v_cnt + CNT_ONE : '0;
        de          = h_active && v_active;
        hs_raw      = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_raw      = (v_cnt >= VS_START) && (v_cnt < VS_END);
        frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    // Delay the flags by the compositor latency so they line up with VGA_data.
    generate
        if (DATA_LATENCY == 0) begin : g_direct
            assign de_dly = de;
            assign hs_dly = hs_raw;
            assign vs_dly = vs_raw;
        end else begin : g_pipe
            logic [DATA_LATENCY-1:0] de_sr;
            logic [DATA_LATENCY-1:0] hs_sr;
            logic [DATA_LATENCY-1:0] vs_sr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    de_sr <= '0;
                    hs_sr <= '0;
                    vs_sr <= '0;
                end else begin
                    de_sr <= DATA_LATENCY'({de_sr, de});
                    hs_sr <= DATA_LATENCY'({hs_sr, hs_raw});
                    vs_sr <= DATA_LATENCY'({vs_sr, vs_raw});
                end
            end

            assign de_dly = de_sr[DATA_LATENCY-1];
            assign hs_dly = hs_sr[DATA_LATENCY-1];
            assign vs_dly = vs_sr[DATA_LATENCY-1];
        end
    endgenerate

    // Pin register; colour is gated so blanked input data never reaches the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {VGA_r, VGA_g, VGA_b} <= 12'h000;
            VGA_hs                <= ~HS_POL;
            VGA_vs                <= ~VS_POL;
        end else begin
            {VGA_r, VGA_g, VGA_b} <= de_dly ? VGA_data : 12'h000;
            VGA_hs                <= hs_dly ? HS_POL : ~HS_POL;
            VGA_vs                <= vs_dly ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_driver.sv
// Bench for vga_timing_driver: three instances share one clock and reset.
//   A: default 640x480 geometry, latency 3
//   B: small 16x12 geometry with active-high hsync, latency 3 (full frames fit in the run)
//   C: default geometry, latency 0
// n is the cycle index since the first edge after reset release (-1 while in reset).
module tb_vga_timing_driver;

    typedef struct packed {
        int   ha, hf, hs, hb, va, vf, vs, vb, lat;
        logic hpol, vpol;
    } geom_t;

    localparam geom_t GA = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, lat:3, hpol:1'b0, vpol:1'b0};
    localparam geom_t GB = '{ha:8, hf:2, hs:3, hb:3, va:6, vf:2, vs:2, vb:2, lat:3, hpol:1'b1, vpol:1'b0};
    localparam geom_t GC = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, lat:0, hpol:1'b0, vpol:1'b0};

    logic clk;
    logic rst_n;

    logic [11:0] data_a, data_b, data_c;
    logic [10:0] xpos_a, xpos_b, xpos_c, ypos_a, ypos_b, ypos_c;
    logic        fs_a, fs_b, fs_c;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic        hs_a, hs_b, hs_c, vs_a, vs_b, vs_c;

    int n;
    bit white;
    int n_checks;
    int n_pass;

    vga_timing_driver u_dut_a (
        .clk(clk), .rst_n(rst_n), .VGA_data(data_a),
        .VGA_xpos(xpos_a), .VGA_ypos(ypos_a), .frame_start(fs_a),
        .VGA_r(r_a), .VGA_g(g_a), .VGA_b(b_a), .VGA_hs(hs_a), .VGA_vs(vs_a)
    );

    vga_timing_driver #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .DATA_LATENCY(3), .HS_POL(1'b1), .VS_POL(1'b0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .VGA_data(data_b),
        .VGA_xpos(xpos_b), .VGA_ypos(ypos_b), .frame_start(fs_b),
        .VGA_r(r_b), .VGA_g(g_b), .VGA_b(b_b), .VGA_hs(hs_b), .VGA_vs(vs_b)
    );

    vga_timing_driver #(.DATA_LATENCY(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .VGA_data(data_c),
        .VGA_xpos(xpos_c), .VGA_ypos(ypos_c), .frame_start(fs_c),
        .VGA_r(r_c), .VGA_g(g_c), .VGA_b(b_c), .VGA_hs(hs_c), .VGA_vs(vs_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    endtask

    function automatic int htot(input geom_t g);
        return g.ha + g.hf + g.hs + g.hb;
    endfunction

    function automatic int vtot(input geom_t g);
        return g.va + g.vf + g.vs + g.vb;
    endfunction

    function automatic logic [10:0] pos_x(input geom_t g, input int m);
        int h;
        if (m < 0) return 11'd0;
        h = m % htot(g);
        return (h < g.ha) ? 11'(h + 1) : 11'd0;
    endfunction

    function automatic logic [10:0] pos_y(input geom_t g, input int m);
        int v;
        if (m < 0) return 11'd0;
        v = (m / htot(g)) % vtot(g);
        return (v < g.va) ? 11'(v + 1) : 11'd0;
    endfunction

    function automatic logic [11:0] pattern(input logic [10:0] x, input logic [10:0] y);
        return {x[3:0], y[3:0], 4'hA};
    endfunction

    // Compositor model: answers the position presented lat cycles ago.
    function automatic logic [11:0] data_for(input geom_t g, input int cyc);
        int m;
        if (cyc < 0 || white) return 12'hFFF;
        m = cyc - g.lat;
        if (m < 0) return 12'h5A5;
        return pattern(pos_x(g, m), pos_y(g, m));
    endfunction

    task automatic drive_data();
        data_a = data_for(GA, n);
        data_b = data_for(GB, n);
        data_c = data_for(GC, n);
    endtask

    task automatic check_inst(input string nm, input geom_t g, input logic [10:0] x, input logic [10:0] y,
                              input logic fs, input logic [11:0] rgb, input logic hs, input logic vs);
        int m, h, v;
        logic [11:0] e_rgb;
        logic e_hs, e_vs, e_fs;
        m = n - g.lat - 1;
        e_fs = (n >= 0) && ((n % (htot(g) * vtot(g))) == 0);
        if (n < 0 || m < 0) begin
            e_rgb = 12'h000;
            e_hs  = ~g.hpol;
            e_vs  = ~g.vpol;
        end else begin
            h = m % htot(g);
            v = (m / htot(g)) % vtot(g);
            if (h < g.ha && v < g.va) e_rgb = white ? 12'hFFF : pattern(pos_x(g, m), pos_y(g, m));
            else e_rgb = 12'h000;
            e_hs = (h >= g.ha + g.hf && h < g.ha + g.hf + g.hs) ? g.hpol : ~g.hpol;
            e_vs = (v >= g.va + g.vf && v < g.va + g.vf + g.vs) ? g.vpol : ~g.vpol;
        end
        check_eq({nm, ".xpos"}, 32'(x), 32'(pos_x(g, n)));
        check_eq({nm, ".ypos"}, 32'(y), 32'(pos_y(g, n)));
        check_eq({nm, ".fs"}, 32'(fs), 32'(e_fs));
        check_eq({nm, ".rgb"}, 32'(rgb), 32'(e_rgb));
        check_eq({nm, ".hs"}, 32'(hs), 32'(e_hs));
        check_eq({nm, ".vs"}, 32'(vs), 32'(e_vs));
    endtask

    task automatic check_all();
        check_inst("A", GA, xpos_a, ypos_a, fs_a, {r_a, g_a, b_a}, hs_a, vs_a);
        check_inst("B", GB, xpos_b, ypos_b, fs_b, {r_b, g_b, b_b}, hs_b, vs_b);
        check_inst("C", GC, xpos_c, ypos_c, fs_c, {r_c, g_c, b_c}, hs_c, vs_c);
    endtask

    // Hand-computed landmarks for the default and small geometries.
    task automatic directed();
        if (white) begin
            case (n)
                3: check_eq("A.rgb_pre_first", 32'({r_a, g_a, b_a}), 32'h000);
                4: check_eq("A.rgb_first_white", 32'({r_a, g_a, b_a}), 32'hFFF);
                643: check_eq("A.rgb_last_white", 32'({r_a, g_a, b_a}), 32'hFFF);
                644: check_eq("A.rgb_hblank", 32'({r_a, g_a, b_a}), 32'h000);
                default: ;
            endcase
        end else begin
            case (n)
                0: check_eq("A.frame_start", 32'(fs_a), 32'd1);
                1: check_eq("C.rgb_11", 32'({r_c, g_c, b_c}), 32'h11A);
                4: check_eq("A.rgb_11", 32'({r_a, g_a, b_a}), 32'h11A);
                13: check_eq("B.hs_pre", 32'(hs_b), 32'd0);
                14: check_eq("B.hs_on", 32'(hs_b), 32'd1);
                131: check_eq("B.vs_pre", 32'(vs_b), 32'd1);
                132: check_eq("B.vs_on", 32'(vs_b), 32'd0);
                163: check_eq("B.vs_last", 32'(vs_b), 32'd0);
                164: check_eq("B.vs_off", 32'(vs_b), 32'd1);
                192: check_eq("B.frame_again", 32'(fs_b), 32'd1);
                639: check_eq("A.xpos_640", 32'(xpos_a), 32'd640);
                640: check_eq("A.xpos_blank", 32'(xpos_a), 32'd0);
                659: check_eq("A.hs_pre", 32'(hs_a), 32'd1);
                660: check_eq("A.hs_fall", 32'(hs_a), 32'd0);
                755: check_eq("A.hs_last", 32'(hs_a), 32'd0);
                756: check_eq("A.hs_rise", 32'(hs_a), 32'd1);
                800: check_eq("A.ypos_2", 32'(ypos_a), 32'd2);
                default: ;
            endcase
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            n++;
            drive_data();
            check_all();
            directed();
        end
    endtask

    task automatic hold_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        n = -1;
        drive_data();
        #1;
        check_all();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        white = 1'b1;
        n = -1;
        rst_n = 1'b0;
        drive_data();

        hold_reset(10);
        release_reset();
        run(1100);
        check_eq("A.mid_xpos", 32'(xpos_a), 32'd300);
        check_eq("A.mid_ypos", 32'(ypos_a), 32'd2);

        mid_reset();
        white = 1'b0;
        drive_data();
        hold_reset(5);
        release_reset();
        run(1700);

        mid_reset();
        hold_reset(3);
        release_reset();
        run(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
